// File: rtl/stash_buffer.sv
// Circular store of the most recent DEPTH 8-bit samples with a stepping read
// pointer; incoming samples bypass straight to the output while valid.
module stash_buffer #(
  parameter int DEPTH = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sample_in,
  input  logic       sample_in_valid,
  input  logic       next_sample,
  output logic [7:0] sample_out
);

  localparam int PTR_W = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-2 depths work.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (sample_in_valid) begin
        r_mem[r_wrPtr] <= sample_in;
        r_wrPtr        <= (r_wrPtr == LAST_IDX) ? '0 : r_wrPtr + 1'b1;
      end
      if (next_sample) begin
        r_rdPtr <= (r_rdPtr == LAST_IDX) ? '0 : r_rdPtr + 1'b1;
      end
    end
  end

  assign sample_out = sample_in_valid ? sample_in : r_mem[r_rdPtr];

endmodule

// File: tb/tb_stash_buffer.sv
// Scoreboard bench for stash_buffer (DEPTH=5): stimulus queues expected
// outputs, a separate monitor pops and compares them against sample_out.
module tb_stash_buffer;

  logic       clk;
  logic       reset;
  logic [7:0] sample_in;
  logic       sample_in_valid;
  logic       next_sample;
  logic [7:0] sample_out;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  exp_t expQ[$];
  int   numChecks;
  int   numFails;

  stash_buffer #(.DEPTH(5)) dut (
    .clk            (clk),
    .reset          (reset),
    .sample_in      (sample_in),
    .sample_in_valid(sample_in_valid),
    .next_sample    (next_sample),
    .sample_out     (sample_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs on the falling edge so the rising edge sees stable values.
  task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic nxt);
    @(negedge clk);
    sample_in_valid = valid;
    sample_in       = data;
    next_sample     = nxt;
  endtask

  // Queue an expectation; the monitor compares it once inputs have settled.
  task automatic checkOutput(input string name, input logic [7:0] val);
    exp_t e;
    #1;
    e.name = name;
    e.val  = val;
    expQ.push_back(e);
    #1;
  endtask

  // One-cycle next_sample pulse, then check the newly selected entry.
  task automatic stepRead(input string name, input logic [7:0] val);
    applyStimulus(1'b0, 8'h00, 1'b1);
    @(posedge clk);
    #1;
    next_sample = 1'b0;
    checkOutput(name, val);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      wait (expQ.size() > 0);
      e = expQ.pop_front();
      numChecks++;
      if (sample_out !== e.val) begin
        numFails++;
        $display("[TB] FAIL %s: sample_out=0x%02h expected=0x%02h", e.name, sample_out, e.val);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    logic [7:0] seq [5];
    numChecks       = 0;
    numFails        = 0;
    reset           = 1'b1;
    sample_in       = 8'h00;
    sample_in_valid = 1'b0;
    next_sample     = 1'b0;

    checkOutput("reset_idle", 8'h00);
    sample_in_valid = 1'b1;
    sample_in       = 8'h3C;
    checkOutput("reset_bypass", 8'h3C);
    sample_in_valid = 1'b0;
    sample_in       = 8'h00;

    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("idle_after_reset", 8'h00);

    // Write 0..6 through a 5-entry store: entries 0,1 get overwritten by 5,6.
    for (int v = 0; v < 7; v++) begin
      applyStimulus(1'b1, 8'(v), 1'b0);
      checkOutput($sformatf("bypass_%0d", v), 8'(v));
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("after_wrap_rd0", 8'h05);

    seq[0] = 8'h06; seq[1] = 8'h02; seq[2] = 8'h03; seq[3] = 8'h04; seq[4] = 8'h05;
    for (int i = 0; i < 5; i++) begin
      stepRead($sformatf("read_cycle_%0d", i), seq[i]);
    end

    // rd=0, wr=2: bring rd to 2 so both pointers match.
    stepRead("align_rd1", 8'h06);
    stepRead("align_rd2", 8'h02);

    applyStimulus(1'b1, 8'hAA, 1'b1);
    checkOutput("simul_bypass", 8'hAA);
    @(posedge clk);
    #1;
    sample_in_valid = 1'b0;
    next_sample     = 1'b0;
    checkOutput("simul_rd3", 8'h03);
    stepRead("simul_rd4", 8'h04);
    stepRead("simul_rd0", 8'h05);
    stepRead("simul_rd1", 8'h06);
    stepRead("simul_mem2", 8'hAA);

    // wr should now be 3: next write lands where rd steps to next.
    applyStimulus(1'b1, 8'h11, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("wr3_rd2_unchanged", 8'hAA);
    stepRead("wr3_written", 8'h11);

    applyStimulus(1'b1, 8'h22, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0);
    @(negedge clk);
    sample_in_valid = 1'b0;
    #2;
    reset = 1'b1;
    checkOutput("async_reset_out", 8'h00);
    sample_in_valid = 1'b1;
    sample_in       = 8'h77;
    checkOutput("async_reset_bypass", 8'h77);
    sample_in_valid = 1'b0;
    sample_in       = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("post_reset_rd0", 8'h00);
    for (int i = 0; i < 5; i++) begin
      stepRead($sformatf("post_reset_entry_%0d", i), 8'h00);
    end
    applyStimulus(1'b1, 8'h5A, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("post_reset_wr0", 8'h5A);

    for (int i = 0; i < 100 && expQ.size() > 0; i++) #1;
    if (expQ.size() > 0) begin
      numFails++;
      $display("[TB] FAIL scoreboard_drain: pending=%0d expected=0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
